// File: rtl/trv32i_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trv32i_mem_pkg : shared types and constants for the memory arbiter   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package trv32i_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_DATA  = 1'b0,
        OWN_FETCH = 1'b1
    } arb_owner_t;

    // Wide enough for any bus up to 1024 bits; users slice the low bits.
    localparam logic [127:0] BE_ALL = '1;

endpackage
`default_nettype wire

// File: rtl/arb_wait_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arb_wait_timer : counts enabled cycles, flags the TIMEOUT-th one     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module arb_wait_timer #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned   CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Expiry fires in the cycle that would make the count reach TIMEOUT,
    // so the caller leaves after exactly TIMEOUT waiting cycles.
    assign expired_o = (TIMEOUT != 0) && enable_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arbiter : shares one memory port between fetch and load/store    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mem_arbiter
    import trv32i_mem_pkg::*;
#(
    parameter int unsigned B_WIDTH    = 32,
    parameter int unsigned A_WIDTH    = 32,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_req,
    input  logic [A_WIDTH-1:0]   if_addr,
    output logic [B_WIDTH-1:0]   if_rdata,
    output logic                 if_ack,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [A_WIDTH-1:0]   d_addr,
    input  logic [B_WIDTH-1:0]   d_wdata,
    input  logic [B_WIDTH/8-1:0] d_be,
    output logic [B_WIDTH-1:0]   d_rdata,
    output logic                 d_ack,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [A_WIDTH-1:0]   mem_addr,
    output logic [B_WIDTH-1:0]   mem_wdata,
    output logic [B_WIDTH/8-1:0] mem_be,
    input  logic [B_WIDTH-1:0]   mem_rdata,
    input  logic                 mem_ack,
    output logic                 busy,
    output logic                 err
);

    localparam int unsigned   BE_W       = B_WIDTH / 8;
    localparam int unsigned   SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    arb_state_t          state_q, state_d;
    arb_owner_t          owner_q, owner_d;
    logic [SW-1:0]       starve_q, starve_d;
    logic                grant;
    logic                timeout;
    logic                done;

    logic                mem_req_q, mem_we_q, if_ack_q, d_ack_q, busy_q, err_q;
    logic [A_WIDTH-1:0]  mem_addr_q;
    logic [B_WIDTH-1:0]  mem_wdata_q, if_rdata_q, d_rdata_q;
    logic [BE_W-1:0]     mem_be_q;

    arb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (state_q != BUSY),
        .enable_i  ((state_q == BUSY) && !mem_ack),
        .expired_o (timeout)
    );

    assign done = (state_q == BUSY) && (mem_ack || timeout);

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        starve_d = starve_q;
        grant    = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_req || if_req) begin
                    state_d = BUSY;
                    grant   = 1'b1;
                    if (if_req && (!d_req || starve_q == STARVE_LIM)) begin
                        owner_d  = OWN_FETCH;
                        starve_d = '0;
                    end else begin
                        owner_d = OWN_DATA;
                        // Fetch lost; it cannot be at the limit here or it would have won.
                        if (if_req) begin
                            starve_d = starve_q + 1'b1;
                        end
                    end
                end
            end
            BUSY:    if (done) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_DATA;
            starve_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
            busy_q   <= (state_d != IDLE);
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;

            if (grant) begin
                mem_req_q <= 1'b1;
                if (owner_d == OWN_FETCH) begin
                    mem_we_q    <= 1'b0;
                    mem_addr_q  <= if_addr;
                    mem_wdata_q <= '0;
                    mem_be_q    <= BE_ALL[BE_W-1:0];
                end else begin
                    mem_we_q    <= d_we;
                    mem_addr_q  <= d_addr;
                    mem_wdata_q <= d_wdata;
                    mem_be_q    <= d_be;
                end
            end

            if (done) begin
                mem_req_q <= 1'b0;
                if (owner_q == OWN_FETCH) begin
                    if_ack_q <= 1'b1;
                end else begin
                    d_ack_q <= 1'b1;
                end
                // A real ack wins over a coincident expiry.
                if (mem_ack) begin
                    if (!mem_we_q) begin
                        if (owner_q == OWN_FETCH) if_rdata_q <= mem_rdata;
                        else                      d_rdata_q  <= mem_rdata;
                    end
                end else begin
                    err_q <= 1'b1;
                    if (owner_q == OWN_FETCH) if_rdata_q <= '0;
                    else                      d_rdata_q  <= '0;
                end
            end
        end
    end

    assign if_rdata  = if_rdata_q;
    assign if_ack    = if_ack_q;
    assign d_rdata   = d_rdata_q;
    assign d_ack     = d_ack_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_arbiter : directed self-checking bench for mem_arbiter        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        busy;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .B_WIDTH    (32),
        .A_WIDTH    (32),
        .STARVE_MAX (4),
        .TIMEOUT    (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_be      (d_be),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .busy      (busy),
        .err       (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_be = '0; mem_rdata = '0; mem_ack = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_err",     32'(err),     32'd0);
        check("rst_acks",    {30'd0, if_ack, d_ack}, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_d_rdata",  d_rdata,  32'd0);

        // Fetch only, zero-latency memory
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        check("f1_mem_req",  32'(mem_req), 32'd1);
        check("f1_mem_addr", mem_addr,     32'h100);
        check("f1_mem_we",   32'(mem_we),  32'd0);
        check("f1_mem_be",   32'(mem_be),  32'hF);
        check("f1_busy",     32'(busy),    32'd1);
        check("f1_if_ack_early", 32'(if_ack), 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h00500093;
        tick();
        check("f1_if_ack",   32'(if_ack),  32'd1);
        check("f1_if_rdata", if_rdata,     32'h00500093);
        check("f1_mem_req_low", 32'(mem_req), 32'd0);
        check("f1_d_ack",    32'(d_ack),   32'd0);
        if_req = 1'b0; mem_ack = 1'b0;
        tick();
        check("f1_ack_pulse", 32'(if_ack), 32'd0);
        check("f1_idle_busy", 32'(busy),   32'd0);

        // Load then store: store must not disturb the captured load data
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        tick();
        check("ld_mem_we", 32'(mem_we), 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        tick();
        check("ld_d_ack",   32'(d_ack), 32'd1);
        check("ld_d_rdata", d_rdata,    32'h12345678);
        d_req = 1'b0; mem_ack = 1'b0;
        tick();
        d_req = 1'b1; d_we = 1'b1; d_wdata = 32'hDEADBEEF; d_be = 4'hF;
        tick();
        check("st_mem_we",    32'(mem_we), 32'd1);
        check("st_mem_wdata", mem_wdata,   32'hDEADBEEF);
        mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
        tick();
        check("st_d_ack",   32'(d_ack), 32'd1);
        check("st_d_rdata", d_rdata,    32'h12345678);
        d_req = 1'b0; mem_ack = 1'b0;
        tick();

        // Simultaneous requests, latency 2: data first, then fetch
        if_req = 1'b1; if_addr = 32'h104;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hCAFEBABE; d_be = 4'b0011;
        tick();
        check("both_mem_we",    32'(mem_we), 32'd1);
        check("both_mem_addr",  mem_addr,    32'h2000);
        check("both_mem_wdata", mem_wdata,   32'hCAFEBABE);
        check("both_mem_be",    32'(mem_be), 32'h3);
        tick();
        check("both_hold_req",  32'(mem_req), 32'd1);
        tick();
        mem_ack = 1'b1;
        tick();
        check("both_d_ack",  32'(d_ack),  32'd1);
        check("both_if_ack", 32'(if_ack), 32'd0);
        d_req = 1'b0; mem_ack = 1'b0;
        tick();
        tick();
        check("both_f_addr",  mem_addr,     32'h104);
        check("both_f_we",    32'(mem_we),  32'd0);
        check("both_f_be",    32'(mem_be),  32'hF);
        check("both_f_wdata", mem_wdata,    32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h00000013;
        tick();
        check("both_f_ack",   32'(if_ack), 32'd1);
        check("both_f_rdata", if_rdata,    32'h00000013);
        if_req = 1'b0; mem_ack = 1'b0;
        tick();

        // Starvation guard: two rounds of four data grants then one fetch
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; if_req = 1'b1; if_addr = 32'h108;
        mem_ack = 1'b1; mem_rdata = 32'hA5A5A5A5;
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < 5; i++) begin
                tick();
                check($sformatf("starve_addr_%0d_%0d", j, i), mem_addr,
                      (i < 4) ? 32'h400 : 32'h108);
                tick();
                check($sformatf("starve_ack_%0d_%0d", j, i), {30'd0, if_ack, d_ack},
                      (i < 4) ? 32'd1 : 32'd2);
                tick();
            end
        end
        d_req = 1'b0; if_req = 1'b0; mem_ack = 1'b0;
        tick();

        // Timeout: memory never answers a fetch
        if_req = 1'b1; if_addr = 32'h10C;
        tick();
        for (int k = 0; k < 8; k++) begin
            check($sformatf("to_req_%0d", k), {30'd0, mem_req, if_ack}, 32'd2);
            tick();
        end
        check("to_mem_req",  32'(mem_req), 32'd0);
        check("to_if_ack",   32'(if_ack),  32'd1);
        check("to_if_rdata", if_rdata,     32'd0);
        check("to_err",      32'(err),     32'd1);
        if_req = 1'b0;
        tick();
        check("to_err_sticky", 32'(err),  32'd1);
        check("to_idle",       32'(busy), 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h77;
        tick();
        check("late_ack_acks",   {30'd0, if_ack, d_ack}, 32'd0);
        check("late_ack_req",    32'(mem_req), 32'd0);
        check("late_ack_busy",   32'(busy),    32'd0);
        check("late_ack_rdata",  if_rdata,     32'd0);
        check("late_ack_err",    32'(err),     32'd1);
        mem_ack = 1'b0;
        tick();

        // Reset in the middle of a load, then the load is re-served
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
        tick();
        check("rb_mem_req", 32'(mem_req), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        check("rb_mem_req_low", 32'(mem_req), 32'd0);
        check("rb_busy",        32'(busy),    32'd0);
        check("rb_err",         32'(err),     32'd0);
        check("rb_d_ack",       32'(d_ack),   32'd0);
        rst = 1'b0;
        tick();
        check("rb_regrant_req",  32'(mem_req), 32'd1);
        check("rb_regrant_addr", mem_addr,     32'h500);
        mem_ack = 1'b1; mem_rdata = 32'hBEEF0001;
        tick();
        check("rb_d_ack_final", 32'(d_ack), 32'd1);
        check("rb_d_rdata",     d_rdata,    32'hBEEF0001);
        d_req = 1'b0; mem_ack = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Single-port memory arbiter that shares one unified instruction/data memory port between the TRV32I core's fetch requester and load/store requester. It sits between TRV32I_core and a single-port memory and replaces the separate instruction and data memory paths.
- Arbitration: fixed priority to data, with a starvation guard for fetch.
- Handshake: request/acknowledge on every side.
- Timeout: a memory that never acknowledges is detected and the stuck transfer is aborted.

Parameters:
B_WIDTH, 32, data bus width.
A_WIDTH, 32, address width.
STARVE_MAX, 4, consecutive lost arbitrations after which fetch wins (≥1).
TIMEOUT, 64, cycles in BUSY without mem_ack before abort; 0 disables the timeout.

Ports:
clk  in  1  clock; all logic is rising-edge.
rst  in  1  synchronous, active-high reset.
if_req  in  1  fetch request; held until if_ack.
if_addr  in  A_WIDTH  fetch address (pc).
if_rdata  out  B_WIDTH  fetched instruction, registered.
if_ack  out  1  one-cycle completion pulse to fetch.
d_req  in  1  data request; held until d_ack.
d_we  in  1  1 = store, 0 = load.
d_addr  in  A_WIDTH  data address.
d_wdata  in  B_WIDTH  store data.
d_be  in  B_WIDTH/8  byte enables.
d_rdata  out  B_WIDTH  load data, registered.
d_ack  out  1  one-cycle completion pulse to data.
mem_req  out  1  memory request; held until mem_ack.
mem_we  out  1  memory write enable.
mem_addr  out  A_WIDTH  memory address.
mem_wdata  out  B_WIDTH  memory write data.
mem_be  out  B_WIDTH/8  memory byte enables (all ones for fetch).
mem_rdata  in  B_WIDTH  memory read data; valid with mem_ack.
mem_ack  in  1  memory completion; may assert in the same cycle mem_req first rises.
busy  out  1  state != IDLE.
err  out  1  sticky timeout flag; cleared only by rst.

Behaviour:
- Reset: all outputs 0, state IDLE, starve_cnt 0, wait_cnt 0, owner DATA.
- Reset mid-transfer: mem_req is 0 the cycle after rst is sampled; no ack is issued for the aborted transfer.
- States and transitions:
  - IDLE → BUSY when any request is present.
  - BUSY → RESP on mem_ack, or on timeout.
  - RESP → IDLE unconditionally.
- Grant in IDLE:
  - d_req alone → DATA.
  - if_req alone → FETCH.
  - Both: DATA, unless starve_cnt == STARVE_MAX, then FETCH.
- starve_cnt:
  - +1 when if_req loses arbitration.
  - Cleared on a FETCH grant.
  - Saturates at STARVE_MAX.
- On grant (IDLE→BUSY edge):
  - mem_addr, mem_we, mem_wdata and mem_be are registered from the winner; mem_req=1.
  - For FETCH: mem_we=0, mem_be all ones, mem_wdata=0.
  - mem_* fields stay stable until leaving BUSY.
- BUSY exit on mem_ack:
  - mem_req→0 on the next edge.
  - For a read, mem_rdata is captured into the owner's rdata register.
  - Store completion leaves d_rdata unchanged.
- RESP: the owner's ack=1 for exactly one cycle.
- Requester rule: req is deasserted or changed in the cycle after ack. A req still high in IDLE is treated as a new request.
- Latency, with request first seen in IDLE at cycle t and memory latency L (mem_ack at t+1+L):
  - mem_req rises at t+1.
  - Ack pulses at t+2+L.
  - Minimum ack at t+2 (L=0).
  - Back-to-back throughput: one transfer per L+3 cycles.
- Timeout:
  - wait_cnt counts BUSY cycles without mem_ack.
  - When wait_cnt == TIMEOUT: mem_req drops, err sets, go to RESP.
  - The owner's ack pulses with rdata = 0.
  - A late mem_ack is ignored outside BUSY.
- mem_ack in IDLE or RESP is ignored.
- Address and data are not modified: no alignment checks, width passthrough.
- Combinational paths: none from inputs to outputs; all outputs are registered.

Decomposition:
- Shared package trv32i_mem_pkg:
  - arb_state_t {IDLE, BUSY, RESP}.
  - arb_owner_t {OWN_DATA, OWN_FETCH}.
  - Constant BE_ALL for the all-ones byte enable.
- One sub-module, arb_wait_timer: a parameterised timer (clear, enable, expired output) used for the timeout. The TIMEOUT=0 disable is handled inside it.

Test Plan:
1. Fetch only, memory L=0: if_req at t, addr 0x100, mem_rdata 0x00500093 → mem_req at t+1, if_ack at t+2, if_rdata=0x00500093, d_ack never asserts.
2. Simultaneous if_req and d_req (store 0xCAFEBABE to 0x2000, d_be=4'b0011), L=2 → data is served first with mem_we=1, mem_be=4'b0011; d_ack at t+4; fetch is granted next and if_ack follows.
3. Starvation: d_req held continuously, if_req high, STARVE_MAX=4 → after 4 data transfers the 5th grant goes to FETCH; starve_cnt returns to 0.
4. Timeout: TIMEOUT=8, mem_ack never arrives → mem_req high for exactly 8 cycles, then the owner's ack pulses with rdata=0, err=1 and stays 1. A later mem_ack in IDLE has no effect.
5. Reset mid-BUSY: rst for one cycle during a load → next cycle mem_req=0, busy=0, err=0, no d_ack; the request is re-served after rst deasserts.
6. Store completion → d_rdata keeps its prior load value (e.g. 0x12345678) while d_ack pulses.
